// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg
// Shared definitions for the camera-link UART and its receive FIFO:
// data width, bit-counter width, the common FSM state encoding used by
// both the TX and RX machines, and the baud divisor helper.
package uart_fifo_pkg;

  localparam int DATA_W = 8;
  localparam int BIT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_fifo_buf.sv
// uart_fifo_buf
// Synchronous FIFO holding received UART bytes until the host drains them.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Flags are registered from the next-state pointers, so they are exact
// every cycle.
// Ports:
//   clk, reset   system clock, asynchronous active-low reset
//   wr, datin    push strobe and byte
//   rd           pop strobe (ignored while empy)
//   datout, dato popped byte and its one-cycle valid pulse
//   empy, full   occupancy flags
module uart_fifo_buf
  import uart_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] datin,
  input  logic              rd,
  output logic [DATA_W-1:0] datout,
  output logic              dato,
  output logic              empy,
  output logic              full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic              r_empy;
  logic              r_full;
  logic [DATA_W-1:0] r_datout;
  logic              r_dato;

  logic              w_do_rd;
  logic              w_do_wr;
  logic [PTR_W-1:0]  w_wptr_nxt;
  logic [PTR_W-1:0]  w_rptr_nxt;
  logic              w_empy_nxt;
  logic              w_full_nxt;

  // A read frees a slot in the same cycle, so a write is still accepted
  // while full if a pop happens alongside it.
  assign w_do_rd = rd & ~r_empy;
  assign w_do_wr = wr & (~r_full | w_do_rd);

  always_comb begin
    w_wptr_nxt = r_wptr;
    w_rptr_nxt = r_rptr;
    if (w_do_wr) w_wptr_nxt = r_wptr + PTR_ONE;
    if (w_do_rd) w_rptr_nxt = r_rptr + PTR_ONE;
    w_empy_nxt = (w_wptr_nxt == w_rptr_nxt);
    w_full_nxt = (w_wptr_nxt[PTR_W-1] != w_rptr_nxt[PTR_W-1]) &&
                 (w_wptr_nxt[PTR_W-2:0] == w_rptr_nxt[PTR_W-2:0]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_empy   <= 1'b1;
      r_full   <= 1'b0;
      r_dato   <= 1'b0;
      r_datout <= '0;
    end else begin
      r_wptr <= w_wptr_nxt;
      r_rptr <= w_rptr_nxt;
      r_empy <= w_empy_nxt;
      r_full <= w_full_nxt;
      r_dato <= w_do_rd;
      if (w_do_rd) r_datout <= r_mem[r_rptr[PTR_W-2:0]];
    end
  end

  // Storage needs no reset; pointers define what is valid. When full with
  // a simultaneous read, both pointers address the same slot and the read
  // above sees the old contents before this write lands.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr[PTR_W-2:0]] <= datin;
  end

  assign datout = r_datout;
  assign dato   = r_dato;
  assign empy   = r_empy;
  assign full   = r_full;

endmodule

// File: rtl/uart_fifo.sv
// uart_fifo
// 8N1 UART (transmitter and receiver) for the camera serial link, with a
// receive FIFO drained by the host. Single clock domain; the RX line is
// synchronised before use. No TX buffering: one byte per accepted tx_wr.
// Ports:
//   clk, reset          system clock, asynchronous active-low reset
//   uart_rxd, uart_txd  serial in / out, both idle high
//   tx_data, tx_wr      byte to send and its strobe (taken when !tx_busy)
//   tx_busy             TX frame in progress
//   rx_data, rx_avail   last good byte and its one-cycle pulse
//   rx_busy             RX frame in progress (start detect to stop sample)
//   frame_err, ovf      pulses: bad stop bit / good byte lost to full FIFO
//   rd, datout, dato    FIFO pop strobe, popped byte, its valid pulse
//   empy, full          FIFO flags
module uart_fifo
  import uart_fifo_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rxd,
  output logic              uart_txd,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_wr,
  output logic              tx_busy,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_avail,
  output logic              rx_busy,
  output logic              frame_err,
  output logic              ovf,
  input  logic              rd,
  output logic [DATA_W-1:0] datout,
  output logic              dato,
  output logic              empy,
  output logic              full
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  // ---------------------------------------------------------------- TX --
  uart_state_t       r_tx_state;
  uart_state_t       w_tx_state_nxt;
  logic [CNT_W-1:0]  r_tx_cnt;
  logic [CNT_W-1:0]  w_tx_cnt_nxt;
  logic [BIT_W-1:0]  r_tx_bit;
  logic [BIT_W-1:0]  w_tx_bit_nxt;
  logic [DATA_W-1:0] r_tx_shift;
  logic [DATA_W-1:0] w_tx_shift_nxt;
  logic              r_txd;
  logic              w_txd_nxt;

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt + CNT_ONE;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    case (r_tx_state)
      IDLE: begin
        w_tx_cnt_nxt = '0;
        w_tx_bit_nxt = '0;
        if (tx_wr) begin
          w_tx_state_nxt = START;
          w_tx_shift_nxt = tx_data;
        end
      end
      START: begin
        if (r_tx_cnt == CNT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = DATA;
        end
      end
      DATA: begin
        if (r_tx_cnt == CNT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_shift_nxt = {1'b0, r_tx_shift[DATA_W-1:1]};
          w_tx_bit_nxt   = r_tx_bit + BIT_ONE;
          if (r_tx_bit == BIT_LAST) w_tx_state_nxt = STOP;
        end
      end
      STOP: begin
        if (r_tx_cnt == CNT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = IDLE;
        end
      end
      default: w_tx_state_nxt = IDLE;
    endcase

    // Line level is decoded from the next state and registered so the pin
    // never glitches and changes exactly on the bit boundary.
    case (w_tx_state_nxt)
      START:   w_txd_nxt = 1'b0;
      DATA:    w_txd_nxt = w_tx_shift_nxt[0];
      default: w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_state <= IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_txd      <= w_txd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_tx_shift <= w_tx_shift_nxt;
  end

  assign uart_txd = r_txd;
  assign tx_busy  = (r_tx_state != IDLE);

  // ---------------------------------------------------------------- RX --
  logic              r_rxd_p0;
  logic              r_rxd_p1;
  logic              r_rxd_prev;
  uart_state_t       r_rx_state;
  uart_state_t       w_rx_state_nxt;
  logic [CNT_W-1:0]  r_rx_cnt;
  logic [CNT_W-1:0]  w_rx_cnt_nxt;
  logic [BIT_W-1:0]  r_rx_bit;
  logic [BIT_W-1:0]  w_rx_bit_nxt;
  logic [DATA_W-1:0] r_rx_shift;
  logic [DATA_W-1:0] w_rx_shift_nxt;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_avail;
  logic              r_frame_err;
  logic              r_ovf;
  logic              w_rx_good;
  logic              w_rx_ferr;
  logic              w_full;
  logic              w_empy;

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt + CNT_ONE;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_good      = 1'b0;
    w_rx_ferr      = 1'b0;
    case (r_rx_state)
      IDLE: begin
        w_rx_cnt_nxt = '0;
        w_rx_bit_nxt = '0;
        if (r_rxd_prev && !r_rxd_p1) w_rx_state_nxt = START;
      end
      START: begin
        // Half a bit after the edge: still low means a real start bit and
        // every later sample lands mid-bit; high means it was a glitch.
        if (r_rx_cnt == CNT_MID) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = r_rxd_p1 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_rx_cnt == CNT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rxd_p1, r_rx_shift[DATA_W-1:1]};
          w_rx_bit_nxt   = r_rx_bit + BIT_ONE;
          if (r_rx_bit == BIT_LAST) w_rx_state_nxt = STOP;
        end
      end
      STOP: begin
        if (r_rx_cnt == CNT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = IDLE;
          w_rx_good      = r_rxd_p1;
          w_rx_ferr      = ~r_rxd_p1;
        end
      end
      default: w_rx_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rxd_p0    <= 1'b1;
      r_rxd_p1    <= 1'b1;
      r_rxd_prev  <= 1'b1;
      r_rx_state  <= IDLE;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_data   <= '0;
      r_rx_avail  <= 1'b0;
      r_frame_err <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_rxd_p0    <= uart_rxd;
      r_rxd_p1    <= r_rxd_p0;
      r_rxd_prev  <= r_rxd_p1;
      r_rx_state  <= w_rx_state_nxt;
      r_rx_cnt    <= w_rx_cnt_nxt;
      r_rx_bit    <= w_rx_bit_nxt;
      r_rx_avail  <= w_rx_good;
      r_frame_err <= w_rx_ferr;
      // A pop in the same cycle makes room, so only an unaccompanied
      // write into a full FIFO loses the byte.
      r_ovf       <= w_rx_good & w_full & ~rd;
      if (w_rx_good) r_rx_data <= r_rx_shift;
    end
  end

  always_ff @(posedge clk) begin
    r_rx_shift <= w_rx_shift_nxt;
  end

  assign rx_data   = r_rx_data;
  assign rx_avail  = r_rx_avail;
  assign rx_busy   = (r_rx_state != IDLE);
  assign frame_err = r_frame_err;
  assign ovf       = r_ovf;

  // -------------------------------------------------------------- FIFO --
  uart_fifo_buf #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .wr    (w_rx_good),
    .datin (r_rx_shift),
    .rd    (rd),
    .datout(datout),
    .dato  (dato),
    .empy  (w_empy),
    .full  (w_full)
  );

  assign empy = w_empy;
  assign full = w_full;

endmodule

// File: tb/tb_uart_fifo.sv
module tb_uart_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rxd;
  logic       uart_txd;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       rx_busy;
  logic       frame_err;
  logic       ovf;
  logic       rd;
  logic [7:0] datout;
  logic       dato;
  logic       empy;
  logic       full;

  always #5 clk = ~clk;

  uart_fifo #(
    .CLK_FREQ  (1_600_000),
    .BAUD      (100_000),
    .DEPTH_LOG2(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_busy  (tx_busy),
    .rx_data  (rx_data),
    .rx_avail (rx_avail),
    .rx_busy  (rx_busy),
    .frame_err(frame_err),
    .ovf      (ovf),
    .rd       (rd),
    .datout   (datout),
    .dato     (dato),
    .empy     (empy),
    .full     (full)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as a queue plus the expected rx_data.
  logic [7:0] mq[$];
  logic [7:0] exp_rx = 8'h00;

  // Pulse monitor.
  int         n_avail = 0;
  int         n_ferr  = 0;
  int         n_ovf   = 0;
  int         n_dato  = 0;
  logic [7:0] last_dat = 8'h00;

  always @(negedge clk) begin
    if (rx_avail)  n_avail++;
    if (frame_err) n_ferr++;
    if (ovf)       n_ovf++;
    if (dato) begin
      n_dato++;
      last_dat = datout;
    end
  end

  typedef struct {
    logic [7:0] d;
    logic [9:0] line;
  } tx_vec_t;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic [7:0] exp_rx;
  } rx_vec_t;

  typedef struct {
    logic       v;
    logic [7:0] d;
  } rd_vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One TX frame; a second tx_wr with different data mid-frame must be ignored.
  task automatic tx_frame(input logic [7:0] d, input logic [9:0] line, input string nm);
    int bad[10];
    int busy_n;
    busy_n = 0;
    foreach (bad[k]) bad[k] = 0;
    @(negedge clk);
    chk({nm, "_idle"}, 32'(tx_busy), 32'(0));
    tx_data = d;
    tx_wr   = 1'b1;
    for (int j = 0; j < 160; j++) begin
      @(negedge clk);
      if (j == 0) tx_wr = 1'b0;
      if (uart_txd !== line[j/16]) bad[j/16]++;
      if (tx_busy) busy_n++;
      if (j == 50) begin
        tx_data = ~d;
        tx_wr   = 1'b1;
      end
      if (j == 51) tx_wr = 1'b0;
    end
    for (int k = 0; k < 10; k++)
      chk($sformatf("%s_bit%0d_badsamples", nm, k), 32'(bad[k]), 32'(0));
    chk({nm, "_busy_clks"}, 32'(busy_n), 32'(160));
    @(negedge clk);
    chk({nm, "_busy_end"}, 32'(tx_busy), 32'(0));
    chk({nm, "_txd_end"}, 32'(uart_txd), 32'(1));
  endtask

  // Drive one serial frame, 16 clocks per bit, then 8 idle clocks.
  // rd is pulsed so it is sampled on the edge after negedge rd_at.
  task automatic send_byte(input logic [7:0] d, input logic stop, input int rd_at,
                           output int avail_at);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    avail_at = -1;
    for (int n = 0; n < 168; n++) begin
      @(negedge clk);
      if (rx_avail && avail_at < 0) avail_at = n;
      uart_rxd = (n < 160) ? fr[n/16] : 1'b1;
      rd = (n == rd_at);
    end
  endtask

  task automatic rx_chk(input logic [7:0] d, input logic stop, input int rd_at,
                        input string nm, output int at);
    int   a0, f0, o0;
    logic eovf;
    a0 = n_avail; f0 = n_ferr; o0 = n_ovf;
    eovf = 1'b0;
    if (stop) begin
      exp_rx = d;
      if (mq.size() < DEPTH) mq.push_back(d);
      else eovf = 1'b1;
    end
    send_byte(d, stop, rd_at, at);
    chk({nm, "_avail"},  32'(n_avail - a0), 32'(stop));
    chk({nm, "_ferr"},   32'(n_ferr - f0), 32'(!stop));
    chk({nm, "_ovf"},    32'(n_ovf - o0), 32'(eovf));
    chk({nm, "_rxdata"}, 32'(rx_data), 32'(exp_rx));
    chk({nm, "_empy"},   32'(empy), 32'(mq.size() == 0));
    chk({nm, "_full"},   32'(full), 32'(mq.size() == DEPTH));
    chk({nm, "_rxbusy"}, 32'(rx_busy), 32'(0));
  endtask

  // Caller updates the model before calling.
  task automatic do_read(input logic exp_v, input logic [7:0] exp_d, input string nm);
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    chk({nm, "_dato"}, 32'(dato), 32'(exp_v));
    if (exp_v) chk({nm, "_datout"}, 32'(datout), 32'(exp_d));
    chk({nm, "_empy"}, 32'(empy), 32'(mq.size() == 0));
    chk({nm, "_full"}, 32'(full), 32'(mq.size() == DEPTH));
    @(negedge clk);
    chk({nm, "_dato_pulse"}, 32'(dato), 32'(0));
  endtask

  task automatic read_model(input string nm);
    logic [7:0] e;
    if (mq.size() > 0) begin
      e = mq.pop_front();
      do_read(1'b1, e, nm);
    end else begin
      do_read(1'b0, 8'h00, nm);
    end
  endtask

  tx_vec_t tx_tab[5];
  rx_vec_t rx_tab[6];
  rd_vec_t rd_tab[4];

  initial begin
    int         at, lat, a0, f0, o0, d0, nrd;
    logic [7:0] b, popped;

    tx_tab[0] = '{8'hA0, 10'h340};
    tx_tab[1] = '{8'h55, 10'h2AA};
    tx_tab[2] = '{8'hFF, 10'h3FE};
    tx_tab[3] = '{8'h00, 10'h200};
    tx_tab[4] = '{8'h81, 10'h302};

    rx_tab[0] = '{8'h3C, 1'b0, 8'h55};
    rx_tab[1] = '{8'hA5, 1'b1, 8'hA5};
    rx_tab[2] = '{8'h00, 1'b1, 8'h00};
    rx_tab[3] = '{8'hFF, 1'b0, 8'h00};
    rx_tab[4] = '{8'h7E, 1'b1, 8'h7E};
    rx_tab[5] = '{8'h81, 1'b0, 8'h7E};

    rd_tab[0] = '{1'b1, 8'hA5};
    rd_tab[1] = '{1'b1, 8'h00};
    rd_tab[2] = '{1'b1, 8'h7E};
    rd_tab[3] = '{1'b0, 8'h00};

    reset    = 1'b0;
    uart_rxd = 1'b1;
    tx_data  = 8'h00;
    tx_wr    = 1'b0;
    rd       = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_txd",      32'(uart_txd), 32'(1));
    chk("rst_tx_busy",  32'(tx_busy), 32'(0));
    chk("rst_rx_data",  32'(rx_data), 32'(0));
    chk("rst_rx_avail", 32'(rx_avail), 32'(0));
    chk("rst_rx_busy",  32'(rx_busy), 32'(0));
    chk("rst_ferr",     32'(frame_err), 32'(0));
    chk("rst_ovf",      32'(ovf), 32'(0));
    chk("rst_datout",   32'(datout), 32'(0));
    chk("rst_dato",     32'(dato), 32'(0));
    chk("rst_empy",     32'(empy), 32'(1));
    chk("rst_full",     32'(full), 32'(0));
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // TX vector table
    for (int i = 0; i < 5; i++)
      tx_frame(tx_tab[i].d, tx_tab[i].line, $sformatf("tx%0d", i));

    // RX 0x55 then one read
    chk("rx55_pre_empy", 32'(empy), 32'(1));
    rx_chk(8'h55, 1'b1, -1, "rx55", lat);
    void'(mq.pop_front());
    do_read(1'b1, 8'h55, "rd55");
    do_read(1'b0, 8'h00, "rd_empty");

    // RX vector table, then read table
    for (int i = 0; i < 6; i++) begin
      rx_chk(rx_tab[i].d, rx_tab[i].stop, -1, $sformatf("rxtab%0d", i), at);
      chk($sformatf("rxtab%0d_tab_rxdata", i), 32'(rx_data), 32'(rx_tab[i].exp_rx));
    end
    for (int i = 0; i < 4; i++) begin
      if (rd_tab[i].v) void'(mq.pop_front());
      do_read(rd_tab[i].v, rd_tab[i].d, $sformatf("rdtab%0d", i));
    end

    // 4-clock low glitch
    a0 = n_avail; f0 = n_ferr; o0 = n_ovf;
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_avail", 32'(n_avail - a0), 32'(0));
    chk("glitch_ferr",  32'(n_ferr - f0), 32'(0));
    chk("glitch_ovf",   32'(n_ovf - o0), 32'(0));
    chk("glitch_empy",  32'(empy), 32'(1));
    chk("glitch_rxbusy", 32'(rx_busy), 32'(0));

    // 17 bytes 0x00..0x10: full after 16, overflow on the 17th
    for (int i = 0; i < 17; i++) begin
      rx_chk(8'(i), 1'b1, -1, $sformatf("fill%0d", i), at);
      if (i == 15) chk("fill_full16", 32'(full), 32'(1));
    end
    for (int i = 0; i < 16; i++) begin
      void'(mq.pop_front());
      do_read(1'b1, 8'(i), $sformatf("drain%0d", i));
    end

    // Refill, then write and read in the same clock while full
    for (int i = 0; i < 16; i++)
      rx_chk(8'($urandom), 1'b1, -1, $sformatf("refill%0d", i), at);
    b = 8'($urandom);
    popped = mq.pop_front();
    d0 = n_dato;
    rx_chk(b, 1'b1, lat - 1, "simul", at);
    chk("simul_dato_cnt", 32'(n_dato - d0), 32'(1));
    chk("simul_datout",   32'(last_dat), 32'(popped));
    for (int i = 0; i < 17; i++) read_model($sformatf("sdrain%0d", i));

    // Reset in the middle of a TX and an RX frame
    rx_chk(8'h42, 1'b1, -1, "pre_rst", at);
    a0 = n_avail;
    @(negedge clk);
    tx_data = 8'h99;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    fork
      send_byte(8'hC3, 1'b1, -1, at);
      begin
        repeat (70) @(negedge clk);
        chk("midrst_txbusy_before", 32'(tx_busy), 32'(1));
        chk("midrst_rxbusy_before", 32'(rx_busy), 32'(1));
        #2 reset = 1'b0;
        #1;
        chk("midrst_txd",     32'(uart_txd), 32'(1));
        chk("midrst_tx_busy", 32'(tx_busy), 32'(0));
        chk("midrst_rx_busy", 32'(rx_busy), 32'(0));
        chk("midrst_empy",    32'(empy), 32'(1));
        chk("midrst_full",    32'(full), 32'(0));
      end
    join
    mq.delete();
    exp_rx = 8'h00;
    chk("midrst_no_byte", 32'(n_avail - a0), 32'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("postrst_rxdata", 32'(rx_data), 32'(0));
    rx_chk(8'h5A, 1'b1, -1, "postrst", at);
    read_model("postrst_rd");
    b = 8'($urandom);
    tx_frame(b, {1'b1, b, 1'b0}, "postrst_tx");

    // Randomised traffic against the model
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      tx_frame(b, {1'b1, b, 1'b0}, $sformatf("txrnd%0d", i));
    end
    for (int i = 0; i < 30; i++) begin
      rx_chk(8'($urandom), ($urandom_range(0, 9) != 0), -1, $sformatf("rxrnd%0d", i), at);
      nrd = $urandom_range(0, 1);
      for (int k = 0; k < nrd; k++) read_model($sformatf("rdrnd%0d_%0d", i, k));
    end
    for (int i = 0; i < 17; i++) read_model($sformatf("fin%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
